// File: rtl/cachepool_l1_coalescer.sv
// CachePool L1 upstream coalescer: merges same-line narrow reads into one
// line-wide request and fans the line response back out in acceptance order.
module cachepool_l1_coalescer #(
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned LineWidth       = 256,
  parameter int unsigned CoalFactor      = 2,
  parameter int unsigned IdWidth         = 6,
  parameter int unsigned WindowTimeout   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AddrWidth-1:0]         req_addr_i,
  input  logic                         req_write_i,
  input  logic [NarrowDataWidth-1:0]   req_wdata_i,
  input  logic [NarrowDataWidth/8-1:0] req_be_i,
  input  logic [IdWidth-1:0]           req_id_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [NarrowDataWidth-1:0]   rsp_data_o,
  output logic [IdWidth-1:0]           rsp_id_o,
  output logic                         line_req_valid_o,
  input  logic                         line_req_ready_i,
  output logic [AddrWidth-1:0]         line_req_addr_o,
  output logic                         line_req_write_o,
  output logic [LineWidth-1:0]         line_req_wdata_o,
  output logic [LineWidth/8-1:0]       line_req_be_o,
  input  logic                         line_rsp_valid_i,
  output logic                         line_rsp_ready_o,
  input  logic [LineWidth-1:0]         line_rsp_data_i
);

  localparam int unsigned LineBytes   = LineWidth / 8;
  localparam int unsigned NarrowBytes = NarrowDataWidth / 8;
  localparam int unsigned NumWords    = LineWidth / NarrowDataWidth;
  localparam int unsigned OffW        = $clog2(LineBytes);
  localparam int unsigned WordLsb     = $clog2(NarrowBytes);
  localparam int unsigned SelW        = OffW - WordLsb;
  localparam int unsigned TagW        = AddrWidth - OffW;
  localparam int unsigned CntW        = $clog2(CoalFactor + 1);
  localparam int unsigned IdxW        = (CoalFactor > 1) ? $clog2(CoalFactor) : 1;
  localparam int unsigned TmrW        = (WindowTimeout > 1) ? $clog2(WindowTimeout) : 1;

  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, WAIT_RSP, REPLY} state_e;

  state_e                 state_q, state_d;
  logic [TagW-1:0]        tag_q, tag_d;
  logic                   write_q, write_d;
  logic [LineWidth-1:0]   wdata_q, wdata_d;
  logic [LineBytes-1:0]   be_q, be_d;
  logic [LineWidth-1:0]   line_data_q, line_data_d;
  logic [IdWidth-1:0]     ent_id_q [CoalFactor];
  logic [IdWidth-1:0]     ent_id_d [CoalFactor];
  logic [SelW-1:0]        ent_off_q [CoalFactor];
  logic [SelW-1:0]        ent_off_d [CoalFactor];
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [TmrW-1:0]        timer_q, timer_d;
  logic                   line_req_valid_q, line_rsp_ready_q, rsp_valid_q;

  logic [TagW-1:0]        req_tag;
  logic [SelW-1:0]        req_sel;
  logic [LineBytes-1:0]   word_be;
  logic [NarrowDataWidth-1:0] line_words [NumWords];
  logic                   unused_addr;

  assign req_tag     = req_addr_i[AddrWidth-1:OffW];
  assign req_sel     = req_addr_i[OffW-1:WordLsb];
  assign word_be     = LineBytes'({NarrowBytes{1'b1}}) << (req_sel * NarrowBytes);
  assign unused_addr = ^req_addr_i[WordLsb-1:0];

  for (genvar w = 0; w < NumWords; w++) begin : g_words
    assign line_words[w] = line_data_q[w*NarrowDataWidth +: NarrowDataWidth];
  end

  // Next-state and buffer update
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    line_data_d = line_data_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    req_ready_o = 1'b0;
    for (int i = 0; i < CoalFactor; i++) begin
      ent_id_d[i]  = ent_id_q[i];
      ent_off_d[i] = ent_off_q[i];
    end
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          tag_d        = req_tag;
          write_d      = req_write_i;
          ent_id_d[0]  = req_id_i;
          ent_off_d[0] = req_sel;
          cnt_d        = CntW'(1);
          timer_d      = '0;
          if (req_write_i) begin
            wdata_d = LineWidth'(req_wdata_i) << (req_sel * NarrowDataWidth);
            be_d    = LineBytes'(req_be_i) << (req_sel * NarrowBytes);
            state_d = ISSUE;
          end else begin
            wdata_d = '0;
            be_d    = word_be;
            state_d = (CoalFactor > 1) ? COLLECT : ISSUE;
          end
        end
      end
      COLLECT: begin
        req_ready_o = req_valid_i & ~req_write_i & (req_tag == tag_q);
        if (req_ready_o) begin
          ent_id_d[cnt_q[IdxW-1:0]]  = req_id_i;
          ent_off_d[cnt_q[IdxW-1:0]] = req_sel;
          be_d    = be_q | word_be;
          timer_d = '0;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_d == CntW'(CoalFactor)) state_d = ISSUE;
        end else if (req_valid_i) begin
          state_d = ISSUE;  // flush: conflicting request waits for IDLE
        end else if (timer_q == TmrW'(WindowTimeout - 1)) begin
          state_d = ISSUE;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      ISSUE: begin
        if (line_req_ready_i) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (line_rsp_valid_i) begin
          line_data_d = line_rsp_data_i;
          idx_d       = '0;
          state_d     = REPLY;
        end
      end
      REPLY: begin
        if (rsp_ready_i) begin
          if (CntW'(idx_q) + CntW'(1) == cnt_q) state_d = IDLE;
          else idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      tag_q            <= '0;
      write_q          <= 1'b0;
      wdata_q          <= '0;
      be_q             <= '0;
      line_data_q      <= '0;
      cnt_q            <= '0;
      idx_q            <= '0;
      timer_q          <= '0;
      line_req_valid_q <= 1'b0;
      line_rsp_ready_q <= 1'b0;
      rsp_valid_q      <= 1'b0;
      for (int i = 0; i < CoalFactor; i++) begin
        ent_id_q[i]  <= '0;
        ent_off_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      tag_q            <= tag_d;
      write_q          <= write_d;
      wdata_q          <= wdata_d;
      be_q             <= be_d;
      line_data_q      <= line_data_d;
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      timer_q          <= timer_d;
      line_req_valid_q <= (state_d == ISSUE);
      line_rsp_ready_q <= (state_d == WAIT_RSP);
      rsp_valid_q      <= (state_d == REPLY);
      for (int i = 0; i < CoalFactor; i++) begin
        ent_id_q[i]  <= ent_id_d[i];
        ent_off_q[i] <= ent_off_d[i];
      end
    end
  end

  assign line_req_valid_o = line_req_valid_q;
  assign line_req_addr_o  = {tag_q, OffW'(0)};
  assign line_req_write_o = write_q;
  assign line_req_wdata_o = wdata_q;
  assign line_req_be_o    = be_q;
  assign line_rsp_ready_o = line_rsp_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_id_o         = ent_id_q[idx_q];
  assign rsp_data_o       = write_q ? '0 : line_words[ent_off_q[idx_q]];

endmodule

// File: tb/tb_cachepool_l1_coalescer.sv
// Directed bench for cachepool_l1_coalescer: inputs change on negedge,
// outputs are sampled 1 ns before the next posedge.
module tb_cachepool_l1_coalescer;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write;
  logic [31:0]  req_addr;
  logic [63:0]  req_wdata;
  logic [7:0]   req_be;
  logic [5:0]   req_id;
  logic         rsp_valid, rsp_ready;
  logic [63:0]  rsp_data;
  logic [5:0]   rsp_id;
  logic         lreq_valid, lreq_ready, lreq_write;
  logic [31:0]  lreq_addr;
  logic [255:0] lreq_wdata;
  logic [31:0]  lreq_be;
  logic         lrsp_valid, lrsp_ready;
  logic [255:0] lrsp_data;

  int checks = 0;
  int failures = 0;
  int n_lreq = 0;
  int n_rsp = 0;
  int lreq_base, rsp_base;

  localparam logic [63:0] W0 = 64'h0000_1111_2222_3333;
  localparam logic [63:0] W1 = 64'h4444_5555_6666_7777;
  localparam logic [63:0] W2 = 64'h8888_9999_AAAA_BBBB;
  localparam logic [63:0] W3 = 64'hCCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] LINE_A = {W3, W2, W1, W0};
  localparam logic [255:0] LINE_B = {W0, W1, W2, W3};

  always #5 clk = ~clk;

  cachepool_l1_coalescer dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_be_i(req_be), .req_id_i(req_id),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_id_o(rsp_id),
    .line_req_valid_o(lreq_valid), .line_req_ready_i(lreq_ready), .line_req_addr_o(lreq_addr),
    .line_req_write_o(lreq_write), .line_req_wdata_o(lreq_wdata), .line_req_be_o(lreq_be),
    .line_rsp_valid_i(lrsp_valid), .line_rsp_ready_o(lrsp_ready), .line_rsp_data_i(lrsp_data)
  );

  // Handshake counters to catch lost or duplicated transfers
  always @(posedge clk) begin
    if (!rst && lreq_valid && lreq_ready) n_lreq <= n_lreq + 1;
    if (!rst && rsp_valid && rsp_ready) n_rsp <= n_rsp + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic smp();
    #4;
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] a, input logic [5:0] id);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_id = id;
  endtask

  // Called right after a negedge; returns at the sample point of the ISSUE cycle
  task automatic wait_lreq(input int max_cyc);
    int n;
    n = 0;
    smp();
    while (lreq_valid !== 1'b1 && n < max_cyc) begin
      @(negedge clk); smp(); n++;
    end
    chk("lreq_wait", 256'(n < max_cyc), 256'(1));
  endtask

  // From the ISSUE sample point (lreq_ready=1) to the first REPLY sample point
  task automatic serve(input logic [255:0] data);
    @(negedge clk);
    lrsp_valid = 1'b1; lrsp_data = data;
    smp();
    chk("wait_rsp_ready", 256'(lrsp_ready), 256'(1));
    chk("wait_req_ready", 256'(req_ready), 256'(0));
    @(negedge clk);
    lrsp_valid = 1'b0;
    smp();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 256'(req_ready), 256'(1));
    chk({tag, "_rsp_valid"}, 256'(rsp_valid), 256'(0));
    chk({tag, "_lreq_valid"}, 256'(lreq_valid), 256'(0));
    chk({tag, "_lrsp_ready"}, 256'(lrsp_ready), 256'(0));
    chk({tag, "_lreq_addr"}, 256'(lreq_addr), 256'(0));
    chk({tag, "_lreq_be"}, 256'(lreq_be), 256'(0));
    chk({tag, "_lreq_wdata"}, lreq_wdata, 256'(0));
    chk({tag, "_lreq_write"}, 256'(lreq_write), 256'(0));
    chk({tag, "_rsp_data"}, 256'(rsp_data), 256'(0));
    chk({tag, "_rsp_id"}, 256'(rsp_id), 256'(0));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; req_id = '0; rsp_ready = 1'b1; lreq_ready = 1'b1; lrsp_valid = 1'b0;
    lrsp_data = '0;
    @(negedge clk); @(negedge clk);
    smp();
    check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    // Two same-line reads merged into one line request
    @(negedge clk);
    lreq_base = n_lreq; rsp_base = n_rsp;
    drive_req(1'b0, 32'h5180_0008, 6'd3);
    smp(); chk("t1_ready0", 256'(req_ready), 256'(1));
    @(negedge clk);
    drive_req(1'b0, 32'h5180_0018, 6'd7);
    smp(); chk("t1_ready1", 256'(req_ready), 256'(1));
    @(negedge clk);
    req_valid = 1'b0;
    smp();
    chk("t1_lreq_valid", 256'(lreq_valid), 256'(1));
    chk("t1_lreq_addr", 256'(lreq_addr), 256'(32'h5180_0000));
    chk("t1_lreq_write", 256'(lreq_write), 256'(0));
    chk("t1_lreq_be", 256'(lreq_be), 256'(32'hFF00_FF00));
    chk("t1_issue_ready", 256'(req_ready), 256'(0));
    serve(LINE_A);
    chk("t1_rsp0_valid", 256'(rsp_valid), 256'(1));
    chk("t1_rsp0_id", 256'(rsp_id), 256'(3));
    chk("t1_rsp0_data", 256'(rsp_data), 256'(W1));
    @(negedge clk); smp();
    chk("t1_rsp1_id", 256'(rsp_id), 256'(7));
    chk("t1_rsp1_data", 256'(rsp_data), 256'(W3));
    @(negedge clk); smp();
    chk("t1_done_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("t1_done_ready", 256'(req_ready), 256'(1));
    chk("t1_n_lreq", 256'(n_lreq - lreq_base), 256'(1));
    chk("t1_n_rsp", 256'(n_rsp - rsp_base), 256'(2));

    // Lone read issues after the idle window
    @(negedge clk);
    drive_req(1'b0, 32'h5180_0020, 6'd5);
    @(negedge clk);
    req_valid = 1'b0;
    smp(); chk("t2_cyc1", 256'(lreq_valid), 256'(0));
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk); smp(); chk("t2_cyc_early", 256'(lreq_valid), 256'(0));
    end
    @(negedge clk); smp();
    chk("t2_cyc5", 256'(lreq_valid), 256'(1));
    chk("t2_addr", 256'(lreq_addr), 256'(32'h5180_0020));
    chk("t2_be", 256'(lreq_be), 256'(32'h0000_00FF));
    serve(LINE_B);
    chk("t2_rsp_id", 256'(rsp_id), 256'(5));
    chk("t2_rsp_data", 256'(rsp_data), 256'(W3));
    @(negedge clk); smp();
    chk("t2_done", 256'(rsp_valid), 256'(0));

    // Write goes straight to ISSUE, ack returns zero data
    @(negedge clk);
    drive_req(1'b1, 32'h5180_0010, 6'd9);
    req_wdata = 64'hDEAD_BEEF_0000_0001; req_be = 8'h0F;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    smp();
    chk("t3_lreq_valid", 256'(lreq_valid), 256'(1));
    chk("t3_wdata", lreq_wdata, {64'h0, 64'hDEAD_BEEF_0000_0001, 128'h0});
    chk("t3_be", 256'(lreq_be), 256'(32'h000F_0000));
    chk("t3_write", 256'(lreq_write), 256'(1));
    chk("t3_addr", 256'(lreq_addr), 256'(32'h5180_0000));
    serve(LINE_A);
    chk("t3_rsp_valid", 256'(rsp_valid), 256'(1));
    chk("t3_rsp_id", 256'(rsp_id), 256'(9));
    chk("t3_rsp_data", 256'(rsp_data), 256'(0));
    @(negedge clk); smp();
    chk("t3_done", 256'(rsp_valid), 256'(0));

    // Different-line read flushes the window and waits for IDLE
    @(negedge clk);
    drive_req(1'b0, 32'h5180_0000, 6'd1);
    @(negedge clk);
    drive_req(1'b0, 32'h5180_0040, 6'd2);
    smp(); chk("t4_held_collect", 256'(req_ready), 256'(0));
    @(negedge clk); smp();
    chk("t4_lreq_valid", 256'(lreq_valid), 256'(1));
    chk("t4_lreq_be", 256'(lreq_be), 256'(32'h0000_00FF));
    chk("t4_lreq_addr", 256'(lreq_addr), 256'(32'h5180_0000));
    chk("t4_held_issue", 256'(req_ready), 256'(0));
    serve(LINE_A);
    chk("t4_rsp_id", 256'(rsp_id), 256'(1));
    chk("t4_rsp_data", 256'(rsp_data), 256'(W0));
    chk("t4_held_reply", 256'(req_ready), 256'(0));
    @(negedge clk); smp();
    chk("t4_idle_accept", 256'(req_ready), 256'(1));
    @(negedge clk);
    req_valid = 1'b0;
    wait_lreq(12);
    chk("t4_second_addr", 256'(lreq_addr), 256'(32'h5180_0040));
    serve(LINE_B);
    chk("t4_second_id", 256'(rsp_id), 256'(2));
    chk("t4_second_data", 256'(rsp_data), 256'(W3));
    @(negedge clk); smp();
    chk("t4_done", 256'(rsp_valid), 256'(0));

    // Backpressure on both the line request and the narrow response
    @(negedge clk);
    lreq_base = n_lreq; rsp_base = n_rsp;
    drive_req(1'b0, 32'h5180_0008, 6'd10);
    @(negedge clk);
    drive_req(1'b0, 32'h5180_0010, 6'd11);
    @(negedge clk);
    req_valid = 1'b0; lreq_ready = 1'b0;
    smp();
    for (int k = 0; k < 5; k++) begin
      chk("t5_bp_valid", 256'(lreq_valid), 256'(1));
      chk("t5_bp_addr", 256'(lreq_addr), 256'(32'h5180_0000));
      chk("t5_bp_be", 256'(lreq_be), 256'(32'h00FF_FF00));
      @(negedge clk);
      if (k == 4) lreq_ready = 1'b1;
      smp();
    end
    chk("t5_bp_release", 256'(lreq_valid), 256'(1));
    rsp_ready = 1'b0;
    serve(LINE_A);
    for (int k = 0; k < 3; k++) begin
      chk("t5_rbp_valid", 256'(rsp_valid), 256'(1));
      chk("t5_rbp_id", 256'(rsp_id), 256'(10));
      chk("t5_rbp_data", 256'(rsp_data), 256'(W1));
      @(negedge clk);
      if (k == 2) rsp_ready = 1'b1;
      smp();
    end
    chk("t5_rsp0_id", 256'(rsp_id), 256'(10));
    @(negedge clk); smp();
    chk("t5_rsp1_id", 256'(rsp_id), 256'(11));
    chk("t5_rsp1_data", 256'(rsp_data), 256'(W2));
    @(negedge clk); smp();
    chk("t5_done", 256'(rsp_valid), 256'(0));
    chk("t5_n_lreq", 256'(n_lreq - lreq_base), 256'(1));
    chk("t5_n_rsp", 256'(n_rsp - rsp_base), 256'(2));

    // Reset while waiting for the line response
    @(negedge clk);
    drive_req(1'b0, 32'h5180_0028, 6'd12);
    @(negedge clk);
    req_valid = 1'b0;
    wait_lreq(12);
    @(negedge clk); smp();
    chk("t6_in_wait", 256'(lrsp_ready), 256'(1));
    @(negedge clk);
    rst = 1'b1;
    smp();
    check_reset_vals("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 32'h5180_0018, 6'd4);
    @(negedge clk);
    req_valid = 1'b0;
    wait_lreq(12);
    chk("t6_addr", 256'(lreq_addr), 256'(32'h5180_0000));
    chk("t6_be", 256'(lreq_be), 256'(32'hFF00_0000));
    serve(LINE_A);
    chk("t6_rsp_id", 256'(rsp_id), 256'(4));
    chk("t6_rsp_data", 256'(rsp_data), 256'(W3));
    @(negedge clk); smp();
    chk("t6_done", 256'(rsp_valid), 256'(0));
    chk("t6_idle", 256'(req_ready), 256'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
